div_arbiter: RTL and testbench
==============================

DIV_ARBITER -- requirements
Module: div_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one divider (2..16).
REQ-002 Parameter DIVIDEND_WIDTH, default 64, dividend/quotient width; DIVISOR_WIDTH, default 32, divisor/remainder width; ID_WIDTH = clog2(NUM_REQ), derived, not overridable.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  NUM_REQ  per-requester request valid.
REQ-006 req_ready  output  NUM_REQ  per-requester accept strobe.
REQ-007 req_dividend  input  NUM_REQ*DIVIDEND_WIDTH  flattened dividends, requester i at slice i.
REQ-008 req_divisor  input  NUM_REQ*DIVISOR_WIDTH  flattened divisors, requester i at slice i.
REQ-009 rsp_valid / rsp_ready  output / input  1 / 1  shared response handshake.
REQ-010 rsp_id  output  ID_WIDTH  index of requester owning the response.
REQ-011 rsp_quotient / rsp_remainder / rsp_overflow  output  DIVIDEND_WIDTH / DIVISOR_WIDTH / 1  captured divider results.
REQ-012 rsp_latency  output  8  cycles from div_valid_in to div_valid_out, saturating at 255.
REQ-013 div_valid_in  output  1  start pulse to shared divider.
REQ-014 div_dividend / div_divisor  output  DIVIDEND_WIDTH / DIVISOR_WIDTH  operands to divider.
REQ-015 div_valid_out, div_quotient, div_remainder, div_overflow  input  1, DIVIDEND_WIDTH, DIVISOR_WIDTH, 1  divider result (valid_out is a one-cycle pulse; results valid only in that cycle).

Function
REQ-016 FSM states SHALL be IDLE, ISSUE, WAIT, RESP.
REQ-017 IDLE: if any req_valid set, grant exactly one requester by round-robin, assert its req_ready combinationally in that cycle, latch its operands and ID, go to ISSUE; else stay.
REQ-018 Round-robin: search starts at (last_grant+1) mod NUM_REQ, wrapping; last_grant updates only on accepted grant.
REQ-019 req_ready SHALL be zero in every state other than IDLE, and at most one bit set at any time.
REQ-020 ISSUE: div_valid_in = 1 for exactly one cycle; clear latency counter; go to WAIT.
REQ-021 div_dividend/div_divisor SHALL be driven from the latched operand registers and held constant from ISSUE until leaving WAIT (divider re-samples operands during operation).
REQ-022 WAIT: latency counter increments each cycle, saturating at 255; on div_valid_out = 1 capture quotient, remainder, overflow, latency into response registers and go to RESP.
REQ-023 RESP: rsp_valid = 1; rsp_* stable while rsp_ready = 0; on rsp_valid & rsp_ready go to IDLE (next grant no earlier than following cycle).
REQ-024 Overflow (divisor 0) SHALL be passed through unmodified; no special sequencing by the arbiter.
REQ-025 req_valid deassertion in non-IDLE states SHALL be ignored; changes in req_* for ungranted requesters SHALL not affect latched operands.
REQ-026 div_valid_out outside WAIT SHALL be ignored.
REQ-027 Throughput: one operation per (divider latency + 3) cycles minimum with rsp_ready held high.

Reset
REQ-028 On reset_n = 0, immediately: state IDLE, req_ready 0, rsp_valid 0, div_valid_in 0, all response/operand registers 0, rsp_latency 0, last_grant = NUM_REQ-1 (requester 0 wins first).
REQ-029 Reset asserted mid-WAIT or mid-RESP SHALL abandon the operation with no response; divider reset is the integrator's responsibility.

Verification
REQ-030 req0: 100 / 7, rsp_ready=1 -> one div_valid_in pulse, rsp_id=0, quotient 14, remainder 2, overflow 0.
REQ-031 req0 and req2 held valid continuously -> grant order 0,2,0,2; req_ready never two bits at once.
REQ-032 req1: 5 / 0 -> rsp_overflow 1, rsp_id 1, response otherwise as driven by divider.
REQ-033 rsp_ready low 5 cycles in RESP -> rsp_* unchanged, no req_ready, no div_valid_in until handshake.
REQ-034 req3 operands changed during WAIT -> div_dividend/div_divisor unchanged; result matches original operands.
REQ-035 reset_n pulled low during WAIT, released -> all outputs 0, no response, next request granted to requester 0.

Source files
------------

// File: rtl/div_arbiter.sv
// div_arbiter: round-robin arbiter sharing one multi-cycle divider among NUM_REQ requesters.
// One operation in flight; operands are latched at grant and held on the divider inputs until the result returns.
module div_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DIVIDEND_WIDTH = 64,
    parameter int DIVISOR_WIDTH  = 32,
    localparam int ID_WIDTH      = $clog2(NUM_REQ)
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [NUM_REQ-1:0]                req_valid,
    output logic [NUM_REQ-1:0]                req_ready,
    input  logic [NUM_REQ*DIVIDEND_WIDTH-1:0] req_dividend,
    input  logic [NUM_REQ*DIVISOR_WIDTH-1:0]  req_divisor,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic [ID_WIDTH-1:0]               rsp_id,
    output logic [DIVIDEND_WIDTH-1:0]         rsp_quotient,
    output logic [DIVISOR_WIDTH-1:0]          rsp_remainder,
    output logic                              rsp_overflow,
    output logic [7:0]                        rsp_latency,
    output logic                              div_valid_in,
    output logic [DIVIDEND_WIDTH-1:0]         div_dividend,
    output logic [DIVISOR_WIDTH-1:0]          div_divisor,
    input  logic                              div_valid_out,
    input  logic [DIVIDEND_WIDTH-1:0]         div_quotient,
    input  logic [DIVISOR_WIDTH-1:0]          div_remainder,
    input  logic                              div_overflow
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                    state, state_nxt;
    logic [ID_WIDTH-1:0]       last_grant, grant_id, cand;
    logic                      grant_found;
    logic [7:0]                lat_cnt, lat_inc;
    logic [DIVIDEND_WIDTH-1:0] dvd [NUM_REQ];
    logic [DIVISOR_WIDTH-1:0]  dvs [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
        assign dvd[i] = req_dividend[i*DIVIDEND_WIDTH +: DIVIDEND_WIDTH];
        assign dvs[i] = req_divisor[i*DIVISOR_WIDTH +: DIVISOR_WIDTH];
    end

    // Scan from farthest to nearest so the requester closest after last_grant wins.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand        = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = ID_WIDTH'((int'(last_grant) + k) % NUM_REQ);
            if (req_valid[cand]) begin
                grant_found = 1'b1;
                grant_id    = cand;
            end
        end
    end

    assign lat_inc = (lat_cnt == 8'hFF) ? lat_cnt : lat_cnt + 8'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt    = (state == IDLE)  ? (grant_found ? ISSUE : IDLE) :
                       (state == ISSUE) ? WAIT :
                       (state == WAIT)  ? (div_valid_out ? RESP : WAIT) :
                                          (rsp_ready ? IDLE : RESP);
        req_ready    = (state == IDLE && grant_found) ? NUM_REQ'(1) << grant_id : '0;
        div_valid_in = (state == ISSUE);
        rsp_valid    = (state == RESP);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant    <= ID_WIDTH'(NUM_REQ - 1);
            rsp_id        <= '0;
            div_dividend  <= '0;
            div_divisor   <= '0;
            lat_cnt       <= '0;
            rsp_quotient  <= '0;
            rsp_remainder <= '0;
            rsp_overflow  <= 1'b0;
            rsp_latency   <= '0;
        end else begin
            if (state == IDLE && grant_found) begin
                last_grant   <= grant_id;
                rsp_id       <= grant_id;
                div_dividend <= dvd[grant_id];
                div_divisor  <= dvs[grant_id];
            end
            if (state == ISSUE) lat_cnt <= '0;
            if (state == WAIT) begin
                lat_cnt <= lat_inc;
                if (div_valid_out) begin
                    rsp_quotient  <= div_quotient;
                    rsp_remainder <= div_remainder;
                    rsp_overflow  <= div_overflow;
                    rsp_latency   <= lat_inc;
                end
            end
        end
    end
endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter: scenario tasks plus a randomized scoreboard run against a behavioural divider and round-robin model.
module tb_div_arbiter;
    localparam int N  = 4;
    localparam int DW = 64;
    localparam int SW = 32;

    typedef struct {
        int              id;
        logic [DW+SW:0]  res;
        int              lat;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*DW-1:0] req_dividend = '0;
    logic [N*SW-1:0] req_divisor = '0;
    logic            rsp_valid;
    logic            rsp_ready = 1'b0;
    logic [1:0]      rsp_id;
    logic [DW-1:0]   rsp_quotient;
    logic [SW-1:0]   rsp_remainder;
    logic            rsp_overflow;
    logic [7:0]      rsp_latency;
    logic            div_valid_in;
    logic [DW-1:0]   div_dividend;
    logic [SW-1:0]   div_divisor;
    logic            div_valid_out;
    logic [DW-1:0]   div_quotient;
    logic [SW-1:0]   div_remainder;
    logic            div_overflow;

    int   vectors = 0;
    int   errors = 0;
    int   div_dly = 2;
    logic stray = 1'b0;
    logic dbusy;
    int   dcnt;
    int   vin_cnt = 0;
    int   multi_cnt = 0;
    int   cyc = 0;
    int   grant_q[$];
    int   grant_t[$];

    always #5 clk = ~clk;

    div_arbiter #(.NUM_REQ(N), .DIVIDEND_WIDTH(DW), .DIVISOR_WIDTH(SW)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dividend(req_dividend), .req_divisor(req_divisor),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder),
        .rsp_overflow(rsp_overflow), .rsp_latency(rsp_latency),
        .div_valid_in(div_valid_in), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_valid_out(div_valid_out), .div_quotient(div_quotient),
        .div_remainder(div_remainder), .div_overflow(div_overflow)
    );

    // {overflow, quotient, remainder}; divide-by-zero returns all-ones quotient and the dividend's low bits
    function automatic logic [DW+SW:0] ref_div(input logic [DW-1:0] a, input logic [SW-1:0] b);
        if (b == '0) return {1'b1, {DW{1'b1}}, a[SW-1:0]};
        return {1'b0, a / DW'(b), SW'(a % DW'(b))};
    endfunction

    // Divider stand-in: answers div_dly cycles after the start pulse, re-reading its operand inputs at the end
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dbusy <= 1'b0;
            dcnt <= 0;
            div_valid_out <= 1'b0;
            div_quotient <= '0;
            div_remainder <= '0;
            div_overflow <= 1'b0;
        end else begin
            div_valid_out <= 1'b0;
            if (stray) begin
                div_valid_out <= 1'b1;
                {div_overflow, div_quotient, div_remainder} <= {1'b1, 64'hDEAD_BEEF_0BAD_F00D, 32'h5A5A_A5A5};
            end else if (dbusy ? dcnt == 0 : (div_valid_in && div_dly == 0)) begin
                dbusy <= 1'b0;
                div_valid_out <= 1'b1;
                {div_overflow, div_quotient, div_remainder} <= ref_div(div_dividend, div_divisor);
            end else if (dbusy) begin
                dcnt <= dcnt - 1;
            end else if (div_valid_in) begin
                dbusy <= 1'b1;
                dcnt <= div_dly - 1;
            end
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (div_valid_in) vin_cnt <= vin_cnt + 1;
        if ($countones(req_ready) > 1) multi_cnt <= multi_cnt + 1;
        for (int i = 0; i < N; i++) if (req_ready[i]) begin
            grant_q.push_back(i);
            grant_t.push_back(cyc);
        end
    end

    task automatic set_req(input int i, input logic [DW-1:0] a, input logic [SW-1:0] b);
        req_dividend[i*DW +: DW] = a;
        req_divisor[i*SW +: SW] = b;
    endtask

    function automatic logic [DW-1:0] rand_dvd();
        return ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 1000)) : {$urandom, $urandom};
    endfunction

    function automatic logic [SW-1:0] rand_dvs();
        int r = $urandom_range(0, 5);
        return (r == 0) ? '0 : (r < 3) ? SW'($urandom_range(1, 20)) : SW'($urandom);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        stray = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        grant_q.delete();
        grant_t.delete();
    endtask

    task automatic wait_rsp(input int limit, output bit to);
        to = 1'b1;
        for (int c = 0; c < limit; c++) begin
            @(negedge clk);
            #1;
            if (rsp_valid) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        vectors++;
        if ({req_ready, rsp_valid, div_valid_in} !== '0)
            begin errors++; $display("FAIL reset_ctrl: got ready=%b rsp_valid=%b vin=%b want all 0", req_ready, rsp_valid, div_valid_in); end
        vectors++;
        if ({rsp_id, rsp_overflow, rsp_latency, rsp_quotient, rsp_remainder} !== '0)
            begin errors++; $display("FAIL reset_rsp: got id=%0d q=%h r=%h ovf=%b lat=%0d want 0", rsp_id, rsp_quotient, rsp_remainder, rsp_overflow, rsp_latency); end
        vectors++;
        if ({div_dividend, div_divisor} !== '0)
            begin errors++; $display("FAIL reset_ops: got %h / %h want 0", div_dividend, div_divisor); end
    endtask

    task automatic test_basic();
        int v0;
        bit to;
        do_reset();
        div_dly = 3;
        v0 = vin_cnt;
        set_req(0, 64'd100, 32'd7);
        rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 4'b0001;
        #1;
        vectors++;
        if (req_ready !== 4'b0001) begin errors++; $display("FAIL basic_grant: got %b want 0001", req_ready); end
        @(negedge clk);
        req_valid = '0;
        wait_rsp(50, to);
        vectors++;
        if (to) begin errors++; $display("FAIL basic_timeout: got no response want rsp_valid"); end
        vectors++;
        if ({rsp_id, rsp_overflow} !== 3'b000) begin errors++; $display("FAIL basic_id_ovf: got id=%0d ovf=%b want 0 0", rsp_id, rsp_overflow); end
        vectors++;
        if (rsp_quotient !== 64'd14 || rsp_remainder !== 32'd2)
            begin errors++; $display("FAIL basic_result: got q=%0d r=%0d want 14 2", rsp_quotient, rsp_remainder); end
        vectors++;
        if (rsp_latency !== 8'd4) begin errors++; $display("FAIL basic_latency: got %0d want 4", rsp_latency); end
        @(negedge clk);
        #1;
        vectors++;
        if (rsp_valid !== 1'b0 || vin_cnt - v0 != 1)
            begin errors++; $display("FAIL basic_done: got rsp_valid=%b pulses=%0d want 0 1", rsp_valid, vin_cnt - v0); end
    endtask

    task automatic test_round_robin();
        int e[4] = '{0, 2, 0, 2};
        do_reset();
        div_dly = 1;
        set_req(0, 64'd1000, 32'd9);
        set_req(2, 64'd77, 32'd5);
        rsp_ready = 1'b1;
        req_valid = 4'b0101;
        for (int c = 0; c < 200 && grant_q.size() < 4; c++) @(negedge clk);
        vectors++;
        if (grant_q.size() < 4) begin errors++; $display("FAIL rr_timeout: got %0d grants want 4", grant_q.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if (grant_q[i] != e[i]) begin errors++; $display("FAIL rr_order%0d: got %0d want %0d", i, grant_q[i], e[i]); end
            end
            vectors++;
            if (grant_t[1] - grant_t[0] != div_dly + 4)
                begin errors++; $display("FAIL rr_throughput: got %0d cycles want %0d", grant_t[1] - grant_t[0], div_dly + 4); end
        end
        vectors++;
        if (multi_cnt != 0) begin errors++; $display("FAIL rr_onehot: got %0d multi-bit cycles want 0", multi_cnt); end
        req_valid = '0;
    endtask

    task automatic test_overflow();
        bit to;
        do_reset();
        div_dly = 2;
        set_req(1, 64'd5, 32'd0);
        rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 4'b0010;
        @(negedge clk);
        req_valid = '0;
        wait_rsp(50, to);
        vectors++;
        if (to) begin errors++; $display("FAIL ovf_timeout: got no response want rsp_valid"); end
        vectors++;
        if (rsp_overflow !== 1'b1 || rsp_id !== 2'd1)
            begin errors++; $display("FAIL ovf_flag: got ovf=%b id=%0d want 1 1", rsp_overflow, rsp_id); end
        vectors++;
        if (rsp_quotient !== {DW{1'b1}} || rsp_remainder !== 32'd5)
            begin errors++; $display("FAIL ovf_result: got q=%h r=%0d want all-ones 5", rsp_quotient, rsp_remainder); end
    endtask

    task automatic test_rsp_hold();
        bit to;
        int v0;
        logic [DW+SW+10:0] snap;
        logic [DW-1:0] a = {$urandom, $urandom};
        logic [SW-1:0] b = SW'($urandom_range(1, 100000));
        do_reset();
        div_dly = 2;
        set_req(0, a, b);
        @(negedge clk);
        req_valid = 4'b0001;
        @(negedge clk);
        req_valid = 4'b1111;
        wait_rsp(50, to);
        vectors++;
        if (to) begin errors++; $display("FAIL hold_timeout: got no response want rsp_valid"); end
        vectors++;
        if ({rsp_overflow, rsp_quotient, rsp_remainder} !== ref_div(a, b))
            begin errors++; $display("FAIL hold_result: got q=%h r=%h want %h", rsp_quotient, rsp_remainder, ref_div(a, b)); end
        snap = {rsp_id, rsp_overflow, rsp_latency, rsp_quotient, rsp_remainder};
        v0 = vin_cnt;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            stray = (c == 1);
            #1;
            vectors++;
            if (rsp_valid !== 1'b1 || req_ready !== '0 || {rsp_id, rsp_overflow, rsp_latency, rsp_quotient, rsp_remainder} !== snap)
                begin errors++; $display("FAIL hold_cycle%0d: got valid=%b ready=%b q=%h r=%h want stable response", c, rsp_valid, req_ready, rsp_quotient, rsp_remainder); end
        end
        vectors++;
        if (vin_cnt != v0) begin errors++; $display("FAIL hold_no_issue: got %0d pulses want 0", vin_cnt - v0); end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        vectors++;
        if (rsp_valid !== 1'b0 || req_ready !== 4'b0010)
            begin errors++; $display("FAIL hold_release: got valid=%b ready=%b want 0 0010", rsp_valid, req_ready); end
        req_valid = '0;
    endtask

    task automatic test_operand_hold();
        bit to;
        logic [DW-1:0] a = {$urandom, $urandom};
        logic [SW-1:0] b = SW'($urandom_range(3, 60000));
        do_reset();
        div_dly = 6;
        set_req(3, a, b);
        rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 4'b1000;
        #1;
        vectors++;
        if (req_ready !== 4'b1000) begin errors++; $display("FAIL opnd_grant: got %b want 1000", req_ready); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            req_valid = 4'b0000;
            set_req(3, ~a + DW'(c), b ^ SW'(c + 1));
            #1;
            vectors++;
            if (div_dividend !== a || div_divisor !== b)
                begin errors++; $display("FAIL opnd_hold%0d: got %h / %h want %h / %h", c, div_dividend, div_divisor, a, b); end
        end
        wait_rsp(50, to);
        vectors++;
        if (to || {rsp_overflow, rsp_quotient, rsp_remainder} !== ref_div(a, b) || rsp_id !== 2'd3)
            begin errors++; $display("FAIL opnd_result: got id=%0d q=%h r=%h want 3 %h", rsp_id, rsp_quotient, rsp_remainder, ref_div(a, b)); end
    endtask

    task automatic test_reset_wait();
        int seen = 0;
        do_reset();
        div_dly = 10;
        set_req(2, 64'd12345, 32'd11);
        rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 4'b0100;
        @(negedge clk);
        req_valid = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        vectors++;
        if ({req_ready, rsp_valid, div_valid_in, rsp_id, rsp_overflow, rsp_latency, rsp_quotient, rsp_remainder, div_dividend, div_divisor} !== '0)
            begin errors++; $display("FAIL rstwait_outputs: got ready=%b valid=%b dvd=%h id=%0d want all 0", req_ready, rsp_valid, div_dividend, rsp_id); end
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            #1;
            if (rsp_valid) seen++;
        end
        vectors++;
        if (seen != 0) begin errors++; $display("FAIL rstwait_no_rsp: got %0d response cycles want 0", seen); end
        @(negedge clk);
        req_valid = 4'b1111;
        #1;
        vectors++;
        if (req_ready !== 4'b0001) begin errors++; $display("FAIL rstwait_regrant: got %b want 0001", req_ready); end
        req_valid = '0;
    endtask

    task automatic test_saturation();
        bit to;
        do_reset();
        div_dly = 300;
        set_req(0, 64'd999, 32'd10);
        rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 4'b0001;
        @(negedge clk);
        req_valid = '0;
        wait_rsp(400, to);
        vectors++;
        if (to || rsp_latency !== 8'd255 || rsp_quotient !== 64'd99)
            begin errors++; $display("FAIL sat_latency: got lat=%0d q=%0d want 255 99", rsp_latency, rsp_quotient); end
    endtask

    task automatic test_stray();
        int v0;
        do_reset();
        v0 = vin_cnt;
        @(negedge clk);
        stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        vectors++;
        if (rsp_valid !== 1'b0 || rsp_quotient !== '0 || vin_cnt != v0)
            begin errors++; $display("FAIL stray_idle: got valid=%b q=%h pulses=%0d want 0 0 0", rsp_valid, rsp_quotient, vin_cnt - v0); end
    endtask

    task automatic test_random();
        int rr_last = N - 1;
        bit busy = 1'b0;
        int granted = -1;
        int done_ops = 0;
        int cyc_n = 0;
        int g;
        exp_t eq[$];
        exp_t e;
        logic [N-1:0] exp_ready;
        do_reset();
        while (done_ops < 30 && cyc_n < 5000) begin
            @(negedge clk);
            cyc_n++;
            for (int i = 0; i < N; i++) begin
                if (i == granted) begin
                    set_req(i, rand_dvd(), rand_dvs());
                    req_valid[i] = 1'($urandom_range(0, 1));
                end else if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                    set_req(i, rand_dvd(), rand_dvs());
                    req_valid[i] = 1'b1;
                end else if ($urandom_range(0, 7) == 0) begin
                    set_req(i, rand_dvd(), rand_dvs());
                end
            end
            granted = -1;
            rsp_ready = 1'($urandom_range(0, 1));
            #1;
            g = -1;
            if (!busy) for (int k = 1; k <= N && g < 0; k++) if (req_valid[(rr_last + k) % N]) g = (rr_last + k) % N;
            exp_ready = (g >= 0) ? N'(1) << g : '0;
            vectors++;
            if (req_ready !== exp_ready) begin errors++; $display("FAIL rand_grant: cycle %0d got %b want %b", cyc_n, req_ready, exp_ready); end
            if (g >= 0) begin
                div_dly = $urandom_range(0, 6);
                e.id = g;
                e.res = ref_div(req_dividend[g*DW +: DW], req_divisor[g*SW +: SW]);
                e.lat = div_dly + 1;
                eq.push_back(e);
                rr_last = g;
                busy = 1'b1;
                granted = g;
            end
            if (rsp_valid) begin
                vectors++;
                if (eq.size() == 0) begin
                    errors++; $display("FAIL rand_unexpected: got response id=%0d want none", rsp_id);
                end else if ({rsp_overflow, rsp_quotient, rsp_remainder} !== eq[0].res || rsp_id !== 2'(eq[0].id) || rsp_latency !== 8'(eq[0].lat)) begin
                    errors++;
                    $display("FAIL rand_rsp: got id=%0d res=%h lat=%0d want id=%0d res=%h lat=%0d",
                             rsp_id, {rsp_overflow, rsp_quotient, rsp_remainder}, rsp_latency, eq[0].id, eq[0].res, eq[0].lat);
                end
                if (rsp_ready) begin
                    if (eq.size() != 0) void'(eq.pop_front());
                    busy = 1'b0;
                    done_ops++;
                end
            end
        end
        vectors++;
        if (done_ops < 30) begin errors++; $display("FAIL rand_timeout: got %0d ops want 30", done_ops); end
        req_valid = '0;
    endtask

    initial begin
        reset_n = 1'b0;
        test_reset();
        test_basic();
        test_round_robin();
        test_overflow();
        test_rsp_hold();
        test_operand_hold();
        test_reset_wait();
        test_saturation();
        test_stray();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
